slice_seq_adder: RTL

//  Multi-cycle W-bit adder. Uses one N-bit ripple-carry slice (rc_adder_slice) once per cycle.

---
 rtl/slice_adder_pkg.sv | 18 +
 rtl/slice_seq_adder_slice.sv | 25 ++
 rtl/slice_seq_adder.sv | 100 ++++++++++
 3 files changed

// File: rtl/slice_adder_pkg.sv
// Shared types and helpers for the slice-sequential adder: FSM state encoding
// and the slice-counter width calculation.
package slice_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Counter must index K = w/n slices; a single slice still needs one bit.
  function automatic int sa_cnt_w(input int w, input int n);
    int k;
    k = w / n;
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/slice_seq_adder_slice.sv
// Purely combinational N-bit ripple-carry adder slice, reused once per cycle
// by slice_seq_adder.
module rc_adder_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  logic carry;

  always_comb begin
    s_o   = '0;
    carry = c_i;
    for (int i = 0; i < N; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/slice_seq_adder.sv
// Multi-cycle W-bit adder: one N-bit ripple slice per cycle, LSB slice first,
// carry registered between slices, valid/ready handshake on both sides.
module slice_seq_adder
  import slice_adder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int K  = W / N;
  localparam int CW = sa_cnt_w(W, N);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  if ((N < 1) || (W % N != 0)) begin : g_param_chk
    $error("slice_seq_adder: W (%0d) must be a positive multiple of N (%0d)", W, N);
  end

  sa_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;

  logic [N-1:0]  slice_s;
  logic          slice_c;
  logic [W-1:0]  sum_d;

  rc_adder_slice #(.N(N)) u_slice (
    .a_i (a_q[N-1:0]),
    .b_i (b_q[N-1:0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Each new slice result enters at the MSB end, so after K edges slice 0
  // has walked down to sum[N-1:0].
  assign sum_d = (sum_q >> N) | (W'(slice_s) << (W - N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_c;
          a_q     <= a_q >> N;
          b_q     <= b_q >> N;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cout_q  <= slice_c;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule
